// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-port SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } arb_state_t;

  localparam logic REQ_INERT = 1'b0;
  localparam logic REQ_A2D   = 1'b1;

  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/spi_xact_arbiter_if.sv
// Requester and shared-master handshake signals of the SPI transaction arbiter.
interface spi_xact_arbiter_if;

  logic        wrt0;
  logic [15:0] cmd0;
  logic        done0;
  logic [15:0] rd_data0;
  logic        wrt1;
  logic [15:0] cmd1;
  logic        done1;
  logic [15:0] rd_data1;
  logic        m_wrt;
  logic [15:0] m_cmd;
  logic        m_done;
  logic [15:0] m_rd_data;
  logic        sel;
  logic        busy;
  logic        tmo;

  // Arbiter side.
  modport master (
    input  wrt0, cmd0, wrt1, cmd1, m_done, m_rd_data,
    output done0, rd_data0, done1, rd_data1, m_wrt, m_cmd, sel, busy, tmo
  );

  // Requester / SPI master side.
  modport slave (
    output wrt0, cmd0, wrt1, cmd1, m_done, m_rd_data,
    input  done0, rd_data0, done1, rd_data1, m_wrt, m_cmd, sel, busy, tmo
  );

endinterface

// File: rtl/arb_wdog.sv
// Clearable transaction watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYC-1.
module arb_wdog #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign expire_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_xact_arbiter.sv
// Round-robin arbiter sharing one SPI master between the inertial and A2D requesters,
// with a watchdog that aborts transactions the master never completes.
module spi_xact_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [15:0] TMO_DATA    = 16'h0000
) (
  input logic                clk,
  input logic                rst_n,
  spi_xact_arbiter_if.master bus
);

  arb_state_t  state_d, state_q;
  logic        pend0_d, pend0_q, pend1_d, pend1_q;
  logic [15:0] hold0_d, hold0_q, hold1_d, hold1_q;
  logic        rr_last_d, rr_last_q;
  logic        sel_d, sel_q;
  logic [15:0] m_cmd_d, m_cmd_q;
  logic        done0_d, done0_q, done1_d, done1_q;
  logic        tmo_d, tmo_q;
  logic [15:0] rd_data0_d, rd_data0_q, rd_data1_d, rd_data1_q;
  logic        busy;
  logic        expire;
  logic        grant;
  logic        finish;
  logic [15:0] ret_data;

  assign busy = (state_q == LAUNCH) || (state_q == WAIT);

  arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == LAUNCH),
    .en_i    (state_q == WAIT),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    pend0_d    = pend0_q;
    pend1_d    = pend1_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    rr_last_d  = rr_last_q;
    sel_d      = sel_q;
    m_cmd_d    = m_cmd_q;
    rd_data0_d = rd_data0_q;
    rd_data1_d = rd_data1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    tmo_d      = 1'b0;
    grant      = REQ_INERT;
    finish     = 1'b0;
    ret_data   = TMO_DATA;

    // A request is dropped if one is already pending or its own transaction is in flight.
    if (bus.wrt0 && !pend0_q && !(busy && sel_q == REQ_INERT)) begin
      pend0_d = 1'b1;
      hold0_d = bus.cmd0;
    end
    if (bus.wrt1 && !pend1_q && !(busy && sel_q == REQ_A2D)) begin
      pend1_d = 1'b1;
      hold1_d = bus.cmd1;
    end

    case (state_q)
      IDLE: begin
        if (pend0_q || pend1_q) begin
          grant   = (pend0_q && pend1_q) ? ~rr_last_q : pend1_q;
          sel_d   = grant;
          m_cmd_d = grant ? hold1_q : hold0_q;
          if (grant) pend1_d = 1'b0;
          else       pend0_d = 1'b0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the expiry cycle still counts as a normal completion.
        if (bus.m_done) begin
          finish   = 1'b1;
          ret_data = bus.m_rd_data;
        end else if (expire) begin
          finish   = 1'b1;
          ret_data = TMO_DATA;
          tmo_d    = 1'b1;
        end
        if (finish) begin
          if (sel_q) begin
            rd_data1_d = ret_data;
            done1_d    = 1'b1;
          end else begin
            rd_data0_d = ret_data;
            done0_d    = 1'b1;
          end
          rr_last_d = sel_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
      rr_last_q  <= 1'b1;
      sel_q      <= 1'b0;
      m_cmd_q    <= '0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      rr_last_q  <= rr_last_d;
      sel_q      <= sel_d;
      m_cmd_q    <= m_cmd_d;
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rd_data0 = rd_data0_q;
  assign bus.rd_data1 = rd_data1_q;
  assign bus.m_wrt    = (state_q == LAUNCH);
  assign bus.m_cmd    = m_cmd_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy;
  assign bus.tmo      = tmo_q;

endmodule
